// File: rtl/arc4_pkg.sv
// arc4_pkg: shared scheduler state, phase encoding and key width for the ARC4 core
package arc4_pkg;
  typedef enum logic [2:0] {
    IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, DONE
  } sched_state_t;
  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_KSA  = 2'd2;
  localparam logic [1:0] PH_PRGA = 2'd3;
  localparam int KEY_W = 24;
  function automatic logic [1:0] to_phase(sched_state_t s);
    return s inside {INIT_GO, INIT_WAIT} ? PH_INIT :
           s inside {KSA_GO, KSA_WAIT}   ? PH_KSA  :
           s inside {PRGA_GO, PRGA_WAIT} ? PH_PRGA : PH_IDLE;
  endfunction
endpackage

// File: rtl/arc4_sched_smem_mux.sv
// smem_mux: 3:1 S-memory port multiplexer selected by phase; phase 0 parks the port
module smem_mux
  import arc4_pkg::*;
(
  input  logic [1:0] phase,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wrdata,
  input  logic       init_wren,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] ksa_wrdata,
  input  logic       ksa_wren,
  input  logic [7:0] prga_addr,
  input  logic [7:0] prga_wrdata,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);
  always_comb begin
    s_addr   = phase == PH_INIT ? init_addr   : phase == PH_KSA ? ksa_addr   : phase == PH_PRGA ? prga_addr   : 8'h00;
    s_wrdata = phase == PH_INIT ? init_wrdata : phase == PH_KSA ? ksa_wrdata : phase == PH_PRGA ? prga_wrdata : 8'h00;
    s_wren   = phase == PH_INIT ? init_wren   : phase == PH_KSA ? ksa_wren   : phase == PH_PRGA ? prga_wren   : 1'b0;
  end
endmodule

// File: rtl/arc4_sched.sv
// arc4_sched: sequences init/ksa/prga through en/rdy handshakes and grants them the S memory
module arc4_sched
  import arc4_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key,
  output logic             err,
  output logic [1:0]       phase,
  output logic             init_en,
  output logic             ksa_en,
  output logic             prga_en,
  input  logic             init_rdy,
  input  logic             ksa_rdy,
  input  logic             prga_rdy,
  output logic [KEY_W-1:0] ksa_key,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       ksa_addr,
  input  logic [7:0]       prga_addr,
  input  logic [7:0]       init_wrdata,
  input  logic [7:0]       ksa_wrdata,
  input  logic [7:0]       prga_wrdata,
  input  logic             init_wren,
  input  logic             ksa_wren,
  input  logic             prga_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_wrdata,
  output logic             s_wren
);
  localparam int CW = $clog2(TIMEOUT + 1);
  sched_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic fresh, active, tmo, restart;
  assign active  = state inside {INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT};
  assign tmo     = active && cnt == CW'(TIMEOUT - 1);
  assign restart = (nxt inside {INIT_GO, KSA_GO, PRGA_GO} && nxt != state) || nxt inside {IDLE, DONE};
  assign rdy     = state == IDLE;
  assign phase   = to_phase(state);
  always_comb begin
    nxt     = state;
    init_en = 1'b0;
    ksa_en  = 1'b0;
    prga_en = 1'b0;
    unique case (state)
      IDLE:      nxt = en ? INIT_GO : IDLE;
      INIT_GO:   begin init_en = init_rdy; nxt = init_rdy ? INIT_WAIT : INIT_GO; end
      INIT_WAIT: nxt = !fresh && init_rdy ? KSA_GO : INIT_WAIT;
      KSA_GO:    begin ksa_en = ksa_rdy; nxt = ksa_rdy ? KSA_WAIT : KSA_GO; end
      KSA_WAIT:  nxt = !fresh && ksa_rdy ? PRGA_GO : KSA_WAIT;
      PRGA_GO:   begin prga_en = prga_rdy; nxt = prga_rdy ? PRGA_WAIT : PRGA_GO; end
      PRGA_WAIT: nxt = !fresh && prga_rdy ? DONE : PRGA_WAIT;
      DONE:      nxt = IDLE;
    endcase
    if (tmo) begin
      nxt     = IDLE;
      init_en = 1'b0;
      ksa_en  = 1'b0;
      prga_en = 1'b0;
    end
  end
  // fresh marks the first cycle of a state so a WAIT ignores the client's stale rdy
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      fresh   <= 1'b0;
      err     <= 1'b0;
      ksa_key <= '0;
    end else begin
      state <= nxt;
      fresh <= nxt != state;
      cnt   <= restart ? '0 : cnt + CW'(1);
      if (state == IDLE && en) begin
        ksa_key <= key;
        err     <= 1'b0;
      end else if (tmo) err <= 1'b1;
    end
  end
  smem_mux u_mux (
    .phase(phase),
    .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
    .ksa_addr(ksa_addr),   .ksa_wrdata(ksa_wrdata),   .ksa_wren(ksa_wren),
    .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );
endmodule

// File: tb/tb_arc4_sched.sv
// tb_arc4_sched: stub clients around two schedulers (default and short watchdog) with an event scoreboard
module tb_arc4_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic en0 = 1'b0, en1 = 1'b0;
  logic [23:0] key0 = '0, key1 = '0;
  logic rdy0, rdy1, err0, err1;
  logic [1:0] ph0, ph1;
  logic [23:0] kk0, kk1;
  logic [7:0] sa0, sa1, sd0, sd1;
  logic sw0, sw1;
  logic c_en [2][3];
  logic c_rdy [2][3];
  logic [7:0] c_addr [2][3];
  logic [7:0] c_wrdata [2][3];
  logic c_wren [2][3];
  int lat [2][3];
  int cnt [2][3];
  bit hang [2][3];
  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0;
  bit mon_on = 0;
  logic rdy_prev = 1'b1;
  typedef struct {int kind; int cyc;} ev_t;
  ev_t q[$];

  arc4_sched dut0 (
    .clk(clk), .rst(rst), .en(en0), .rdy(rdy0), .key(key0), .err(err0), .phase(ph0),
    .init_en(c_en[0][0]), .ksa_en(c_en[0][1]), .prga_en(c_en[0][2]),
    .init_rdy(c_rdy[0][0]), .ksa_rdy(c_rdy[0][1]), .prga_rdy(c_rdy[0][2]), .ksa_key(kk0),
    .init_addr(c_addr[0][0]), .ksa_addr(c_addr[0][1]), .prga_addr(c_addr[0][2]),
    .init_wrdata(c_wrdata[0][0]), .ksa_wrdata(c_wrdata[0][1]), .prga_wrdata(c_wrdata[0][2]),
    .init_wren(c_wren[0][0]), .ksa_wren(c_wren[0][1]), .prga_wren(c_wren[0][2]),
    .s_addr(sa0), .s_wrdata(sd0), .s_wren(sw0)
  );
  arc4_sched #(.TIMEOUT(100)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .key(key1), .err(err1), .phase(ph1),
    .init_en(c_en[1][0]), .ksa_en(c_en[1][1]), .prga_en(c_en[1][2]),
    .init_rdy(c_rdy[1][0]), .ksa_rdy(c_rdy[1][1]), .prga_rdy(c_rdy[1][2]), .ksa_key(kk1),
    .init_addr(c_addr[1][0]), .ksa_addr(c_addr[1][1]), .prga_addr(c_addr[1][2]),
    .init_wrdata(c_wrdata[1][0]), .ksa_wrdata(c_wrdata[1][1]), .prga_wrdata(c_wrdata[1][2]),
    .init_wren(c_wren[1][0]), .ksa_wren(c_wren[1][1]), .prga_wren(c_wren[1][2]),
    .s_addr(sa1), .s_wrdata(sd1), .s_wren(sw1)
  );

  // idle stubs drive addr FF / wren 1 so a leaky grant mux is visible
  always_comb begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 3; c++) begin
        c_addr[d][c]   = c_rdy[d][c] ? 8'hFF : 8'((c << 6) | (cnt[d][c] & 63));
        c_wrdata[d][c] = ~c_addr[d][c];
        c_wren[d][c]   = c_rdy[d][c] ? 1'b1 : cnt[d][c][0];
      end
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 3; c++)
        if (rst) begin
          c_rdy[d][c] <= 1'b1;
          cnt[d][c]   <= 0;
        end else if (c_rdy[d][c] && c_en[d][c]) begin
          c_rdy[d][c] <= 1'b0;
          cnt[d][c]   <= lat[d][c];
        end else if (!c_rdy[d][c] && !hang[d][c]) begin
          if (cnt[d][c] == 1) begin
            c_rdy[d][c] <= 1'b1;
            cnt[d][c]   <= 0;
          end else cnt[d][c] <= cnt[d][c] - 1;
        end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic pop_ev(input int kind);
    ev_t e;
    if (q.size() == 0) chk("ev_extra", 32'(q.size()), 32'd1);
    else begin
      e = q.pop_front();
      chk("ev_kind", 32'(kind), 32'(e.kind));
      chk("ev_cyc", 32'(cyc - t0), 32'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < 3; k++) if (c_en[0][k]) pop_ev(k);
      if (rdy0 && !rdy_prev) pop_ev(3);
    end
    rdy_prev <= rdy0;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int e2, e3, ed, ph, g;
    logic [7:0] ea;
    logic ew;
    lat[0] = '{256, 768, 10};
    lat[1] = '{3, 5, 5};
    hang[0] = '{0, 0, 0};
    hang[1] = '{0, 1, 0};
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(rdy0), 32'd1);
    chk("rst_phase", 32'(ph0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_swren", 32'(sw0), 32'd0);
    chk("rst_en", 32'({c_en[0][0], c_en[0][1], c_en[0][2]}), 32'd0);
    chk("rst_rdy1", 32'(rdy1), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    // full run with busy/key disturbance during KSA_WAIT
    e2 = 1 + lat[0][0] + 2;
    e3 = e2 + lat[0][1] + 2;
    ed = e3 + lat[0][2] + 2;
    q.push_back('{0, 1});
    q.push_back('{1, e2});
    q.push_back('{2, e3});
    q.push_back('{3, ed + 1});
    en0 = 1'b1;
    key0 = 24'h00033C;
    t0 = cyc;
    mon_on = 1;
    for (int r = 1; r <= ed + 4; r++) begin
      @(negedge clk);
      if (r == 1) begin
        en0 = 1'b0;
        chk("rdy_low", 32'(rdy0), 32'd0);
      end
      if (r == 300) begin
        en0 = 1'b1;
        key0 = 24'hFFFFFF;
      end
      if (r == 301) en0 = 1'b0;
      ph = r < e2 ? 1 : r < e3 ? 2 : r < ed ? 3 : 0;
      g = ph == 0 ? 0 : ph - 1;
      ea = ph == 0 ? 8'h00 : c_addr[0][g];
      ew = ph == 0 ? 1'b0 : c_wren[0][g];
      chk("phase", 32'(ph0), 32'(ph));
      chk("s_addr", 32'(sa0), 32'(ea));
      chk("s_wren", 32'(sw0), 32'(ew));
      if (r == 302) chk("key_hold", 32'(kk0), 32'h00033C);
    end
    chk("q_empty", 32'(q.size()), 32'd0);
    chk("ksa_key", 32'(kk0), 32'h00033C);
    chk("err0", 32'(err0), 32'd0);
    mon_on = 0;
    // watchdog: ksa stub never returns ready
    @(negedge clk);
    en1 = 1'b1;
    key1 = 24'h123456;
    t0 = cyc;
    for (int r = 1; r <= 110; r++) begin
      @(negedge clk);
      if (r == 1) en1 = 1'b0;
      ph = r <= 5 ? 1 : r <= 105 ? 2 : 0;
      chk("wd_phase", 32'(ph1), 32'(ph));
      chk("wd_rdy", 32'(rdy1), 32'(r >= 106));
      chk("wd_err", 32'(err1), 32'(r >= 106));
      chk("wd_ksa_en", 32'(c_en[1][1]), 32'(r == 6));
    end
    chk("wd_key", 32'(kk1), 32'h123456);
    en1 = 1'b1;
    for (int r = 1; r <= 106; r++) begin
      @(negedge clk);
      if (r == 1) begin
        en1 = 1'b0;
        chk("wd_err_clr", 32'(err1), 32'd0);
      end
      if (r == 50) chk("wd_stall", 32'({ph1, c_en[1][1]}), 32'b100);
      if (r == 106) chk("wd_err2", 32'({err1, rdy1}), 32'b11);
    end
    // reset mid-run during PRGA_WAIT
    lat[0] = '{5, 5, 20};
    @(negedge clk);
    en0 = 1'b1;
    for (int r = 1; r <= 25; r++) begin
      @(negedge clk);
      if (r == 1) en0 = 1'b0;
    end
    chk("mid_phase", 32'(ph0), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rdy", 32'(rdy0), 32'd1);
    chk("mid_phase0", 32'(ph0), 32'd0);
    chk("mid_prga_en", 32'(c_en[0][2]), 32'd0);
    chk("mid_swren", 32'(sw0), 32'd0);
    chk("mid_key", 32'(kk0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
